// File: rtl/score_pkg.sv
// Shared constants, FSM state type and sprite ROM address helper for the score reader.
package score_pkg;

  localparam int GLYPH_W     = 16;
  localparam int GLYPH_H     = 32;
  localparam int GLYPH_BYTES = GLYPH_W * GLYPH_H;
  localparam int NUM_GLYPHS  = 10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    SWAP
  } state_t;

  // Glyphs are stored back to back, row-major, one byte per pixel.
  function automatic int glyph_addr(input logic [3:0] glyph, input logic [4:0] row, input int col);
    return int'(glyph) * GLYPH_BYTES + int'(row) * GLYPH_W + col;
  endfunction

endpackage

// File: rtl/score_sprite_reader_if.sv
// Line-buffer bus: back-bank write port, front-bank read port and bank select.
interface score_sprite_reader_if #(
  parameter int PIX_AW = 6
);
  logic              we;
  logic [PIX_AW-1:0] waddr;
  logic [7:0]        wdata;
  logic [PIX_AW-1:0] raddr;
  logic [7:0]        rdata;
  logic              bank_sel;

  modport master (output we, output waddr, output wdata, output raddr, output bank_sel, input rdata);
  modport slave  (input we, input waddr, input wdata, input raddr, input bank_sel, output rdata);
endinterface

// File: rtl/score_line_buf.sv
// Double-banked scanline buffer; bank_sel names the front (displayed) bank.
module score_line_buf #(
  parameter int PIX_AW = 6
) (
  input logic                  clk,
  input logic                  reset_n,
  score_sprite_reader_if.slave buf_if
);

  logic [7:0] mem [2**(PIX_AW+1)];
  logic [7:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (buf_if.we) begin
      mem[{~buf_if.bank_sel, buf_if.waddr}] <= buf_if.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg <= 8'h00;
    end else begin
      rd_data_reg <= mem[{buf_if.bank_sel, buf_if.raddr}];
    end
  end

  assign buf_if.rdata = rd_data_reg;

endmodule

// File: rtl/score_sprite_reader.sv
// Fetches one scanline of a BCD score from the sprite ROM into the back bank, then swaps banks.
module score_sprite_reader
  import score_pkg::*;
#(
  parameter int  DIGITS = 4,
  parameter int  ROM_AW = 13,
  localparam int PIX_AW = $clog2(GLYPH_W * DIGITS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                line_start,
  input  logic [4:0]          line_row,
  input  logic [4*DIGITS-1:0] score_bcd,
  output logic                busy,
  output logic                done,
  output logic [ROM_AW-1:0]   rom_address,
  output logic                rom_chipselect,
  output logic                rom_clken,
  input  logic [7:0]          rom_readdata,
  input  logic [PIX_AW-1:0]   pix_addr,
  output logic [7:0]          pix_data
);

  localparam int NPIX = GLYPH_W * DIGITS;

  state_t              state_reg, state_next;
  logic [PIX_AW-1:0]   cnt_reg;
  logic [4:0]          row_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [ROM_AW-1:0]   addr_reg;
  logic                cs_reg;
  logic                bank_sel_reg;
  // Two-stage pixel pipeline: issue stage (address on the bus), write stage (data returned).
  logic                iss_vld_reg, iss_zero_reg;
  logic [PIX_AW-1:0]   iss_pix_reg;
  logic                wr_vld_reg, wr_zero_reg;
  logic [PIX_AW-1:0]   wr_pix_reg;

  int                  digit_idx;
  logic [3:0]          nibble;
  logic                pix_ok;
  logic [ROM_AW-1:0]   fetch_addr;

  always_comb begin
    digit_idx  = int'(cnt_reg) / GLYPH_W;
    nibble     = bcd_reg[4*(DIGITS-1-digit_idx) +: 4];
    pix_ok     = (nibble < 4'(NUM_GLYPHS));
    fetch_addr = ROM_AW'(glyph_addr(nibble, row_reg, int'(cnt_reg) % GLYPH_W));
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (line_start) state_next = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (cnt_reg == PIX_AW'(NPIX - 1)) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_vld_reg && wr_pix_reg == PIX_AW'(NPIX - 1)) state_next = SWAP;
      end
      SWAP: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      row_reg      <= '0;
      bcd_reg      <= '0;
      addr_reg     <= '0;
      cs_reg       <= 1'b0;
      bank_sel_reg <= 1'b0;
      iss_vld_reg  <= 1'b0;
      iss_zero_reg <= 1'b0;
      iss_pix_reg  <= '0;
      wr_vld_reg   <= 1'b0;
      wr_zero_reg  <= 1'b0;
      wr_pix_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      iss_vld_reg  <= 1'b0;
      cs_reg       <= 1'b0;
      wr_vld_reg   <= iss_vld_reg;
      wr_zero_reg  <= iss_zero_reg;
      wr_pix_reg   <= iss_pix_reg;
      if (state_reg == IDLE && line_start) begin
        row_reg <= line_row;
        bcd_reg <= score_bcd;
        cnt_reg <= '0;
      end
      if (state_reg == FETCH) begin
        cnt_reg      <= cnt_reg + PIX_AW'(1);
        iss_vld_reg  <= 1'b1;
        iss_pix_reg  <= cnt_reg;
        iss_zero_reg <= !pix_ok;
        cs_reg       <= pix_ok;
        // Non-digit nibbles skip the bus entirely, so the address simply holds.
        if (pix_ok) addr_reg <= fetch_addr;
      end
      // Swap as SWAP is entered so done coincides with the new front bank.
      if (state_reg == DRAIN && state_next == SWAP) begin
        bank_sel_reg <= ~bank_sel_reg;
      end
    end
  end

  assign rom_address    = addr_reg;
  assign rom_chipselect = cs_reg;
  assign rom_clken      = busy;

  score_sprite_reader_if #(.PIX_AW(PIX_AW)) buf_bus ();

  assign buf_bus.we       = wr_vld_reg;
  assign buf_bus.waddr    = wr_pix_reg;
  assign buf_bus.wdata    = wr_zero_reg ? 8'h00 : rom_readdata;
  assign buf_bus.raddr    = pix_addr;
  assign buf_bus.bank_sel = bank_sel_reg;
  assign pix_data         = buf_bus.rdata;

  score_line_buf #(.PIX_AW(PIX_AW)) u_line_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .buf_if  (buf_bus.slave)
  );

endmodule

// File: tb/tb_score_sprite_reader.sv
// Directed and randomized scanline fetches checked cycle by cycle against a behavioural model.
module tb_score_sprite_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [4:0]  line_row = '0;
  logic [15:0] score_bcd = '0;
  logic        busy, done, rom_chipselect, rom_clken;
  logic [12:0] rom_address;
  logic [7:0]  rom_readdata = 8'h00;
  logic [7:0]  rom_key = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_pix  [64];
  logic [7:0] prev_pix [64];
  bit         exp_ok   [64];
  int         exp_addr [64];
  int         exp_last_addr = 0;
  bit         have_prev = 0;

  score_sprite_reader_if #(.PIX_AW(6)) pix_bus ();
  assign pix_bus.we       = 1'b0;
  assign pix_bus.waddr    = '0;
  assign pix_bus.wdata    = '0;
  assign pix_bus.bank_sel = 1'b0;

  score_sprite_reader #(.DIGITS(4), .ROM_AW(13)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .line_start     (line_start),
    .line_row       (line_row),
    .score_bcd      (score_bcd),
    .busy           (busy),
    .done           (done),
    .rom_address    (rom_address),
    .rom_chipselect (rom_chipselect),
    .rom_clken      (rom_clken),
    .rom_readdata   (rom_readdata),
    .pix_addr       (pix_bus.raddr),
    .pix_data       (pix_bus.rdata)
  );

  always #5 clk = ~clk;

  // Sprite ROM: byte = address[7:0] ^ key, one cycle read latency.
  always @(posedge clk) begin
    if (rom_chipselect) rom_readdata <= rom_address[7:0] ^ rom_key;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cs"}, rom_chipselect, 0);
    chk({tag, "_clken"}, rom_clken, 0);
    chk({tag, "_addr"}, rom_address, 0);
    chk({tag, "_pix"}, pix_bus.rdata, 0);
  endtask

  task automatic build_model(input logic [15:0] bcd, input logic [4:0] row);
    for (int p = 0; p < 64; p++) begin
      int nib;
      nib         = (int'(bcd) >> (4 * (3 - p / 16))) & 15;
      exp_ok[p]   = (nib <= 9);
      exp_addr[p] = nib * 512 + int'(row) * 16 + p % 16;
      exp_pix[p]  = exp_ok[p] ? (8'(exp_addr[p]) ^ rom_key) : 8'h00;
    end
  endtask

  task automatic run_line(input logic [15:0] bcd, input logic [4:0] row,
                          input int poke_cycle, input int reset_cycle);
    bit aborted;
    bit exp_cs;
    aborted = 0;
    build_model(bcd, row);
    @(negedge clk);
    line_start = 1'b1;
    score_bcd  = bcd;
    line_row   = row;
    @(negedge clk);
    line_start = 1'b0;
    score_bcd  = 16'($urandom);
    line_row   = 5'($urandom);
    for (int c = 0; c <= 66 && !aborted; c++) begin
      if (c > 0) @(negedge clk);
      if (c == reset_cycle) begin
        reset_n = 1'b0;
        #1;
        check_reset("abort");
        repeat (2) @(negedge clk);
        reset_n       = 1'b1;
        have_prev     = 0;
        exp_last_addr = 0;
        aborted       = 1;
      end else begin
        exp_cs = (c >= 1 && c <= 64) ? exp_ok[c-1] : 1'b0;
        chk("busy", busy, 32'(c < 66));
        chk("done", done, 32'(c == 66));
        chk("clken", rom_clken, 32'(c < 66));
        chk("cs", rom_chipselect, 32'(exp_cs));
        if (exp_cs) exp_last_addr = exp_addr[c-1];
        chk("addr", rom_address, exp_last_addr);
        if (have_prev && c >= 1) chk("front_hold", pix_bus.rdata, prev_pix[(c-1) % 64]);
        line_start    = (c == poke_cycle);
        pix_bus.raddr = 6'(c % 64);
      end
    end
    line_start = 1'b0;
    if (!aborted) begin
      prev_pix  = exp_pix;
      have_prev = 1;
      repeat (2) begin
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end
      pix_bus.raddr = 6'd0;
      for (int p = 0; p < 64; p++) begin
        @(negedge clk);
        chk("front_pix", pix_bus.rdata, exp_pix[p]);
        pix_bus.raddr = 6'(p + 1);
      end
    end
    $display("line bcd=%04h row=%0d poke=%0d rst=%0d aborted=%0d failures=%0d",
             bcd, row, poke_cycle, reset_cycle, aborted, n_fail);
  endtask

  initial begin
    pix_bus.raddr = 6'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("post_reset");

    rom_key = 8'h00;
    run_line(16'h1234, 5'd0, -1, -1);
    @(negedge clk);
    pix_bus.raddr = 6'd16;
    @(negedge clk);
    chk("pix16", pix_bus.rdata, 8'h00);

    rom_key = 8'($urandom);
    run_line(16'h9000, 5'd31, -1, -1);
    run_line(16'hA0F0, 5'($urandom_range(0, 31)), -1, -1);
    run_line(16'($urandom), 5'($urandom), 10, -1);
    run_line(16'($urandom), 5'($urandom), -1, 30);
    run_line(16'($urandom), 5'($urandom), -1, -1);

    rom_key = 8'($urandom);
    run_line(16'($urandom), 5'd3, -1, -1);
    run_line(16'($urandom), 5'd4, -1, -1);

    for (int i = 0; i < 4; i++) begin
      rom_key = 8'($urandom);
      run_line(16'($urandom), 5'($urandom), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
